// File: rtl/gauss_conv_engine.sv
// Gaussian convolution engine: snapshots a SIZE x SIZE kernel on start, MACs one
// window pixel per cycle, then emits a rounded, saturated 8-bit result.
module gauss_conv_engine #(
  parameter int unsigned SIZE       = 3,
  parameter int unsigned NORM_SHIFT = 8
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic [SIZE-1:0][SIZE-1:0][7:0]  kernel,
  input  logic                            start,
  input  logic                            abort,
  input  logic [7:0]                      pixel_in,
  input  logic                            pixel_valid,
  output logic                            pixel_ready,
  output logic [7:0]                      out_pixel,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy,
  output logic                            err
);

  localparam int unsigned ACC_W = 16 + $clog2(SIZE * SIZE);
  localparam int unsigned CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SIZE - 1);
  // Half an LSB of the shifted result; zero when no shift is applied.
  localparam logic [ACC_W:0] RND = ((ACC_W + 1)'(1) << NORM_SHIFT) >> 1;

  typedef enum logic [1:0] {IDLE, ACCUM, NORM, OUT} state_t;

  state_t                          state, state_nxt;
  logic [ACC_W-1:0]                acc, acc_nxt;
  logic [CNT_W-1:0]                col, col_nxt, row, row_nxt;
  logic [SIZE-1:0][SIZE-1:0][7:0]  snap, snap_nxt;
  logic [7:0]                      out_pixel_nxt;
  logic                            out_valid_nxt, pixel_ready_nxt, busy_nxt;
  logic [15:0]                     prod_c;
  logic [ACC_W:0]                  sum_c, shr_c;

  assign err = (SIZE % 2 == 0);

  assign prod_c = 16'(pixel_in) * 16'(snap[row][col]);
  assign sum_c  = {1'b0, acc} + RND;
  assign shr_c  = sum_c >> NORM_SHIFT;

  // State and datapath registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      acc         <= '0;
      col         <= '0;
      row         <= '0;
      snap        <= '0;
      out_pixel   <= '0;
      out_valid   <= 1'b0;
      pixel_ready <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      acc         <= acc_nxt;
      col         <= col_nxt;
      row         <= row_nxt;
      snap        <= snap_nxt;
      out_pixel   <= out_pixel_nxt;
      out_valid   <= out_valid_nxt;
      pixel_ready <= pixel_ready_nxt;
      busy        <= busy_nxt;
    end
  end

  // Next-state and datapath update; abort overrides everything
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    col_nxt       = col;
    row_nxt       = row;
    snap_nxt      = snap;
    out_pixel_nxt = out_pixel;
    out_valid_nxt = out_valid;

    if (abort) begin
      state_nxt     = IDLE;
      acc_nxt       = '0;
      col_nxt       = '0;
      row_nxt       = '0;
      out_valid_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !err) begin
            snap_nxt  = kernel;
            acc_nxt   = '0;
            col_nxt   = '0;
            row_nxt   = '0;
            state_nxt = ACCUM;
          end
        end
        ACCUM: begin
          if (pixel_valid && pixel_ready) begin
            acc_nxt = acc + ACC_W'(prod_c);
            if (col == LAST) begin
              col_nxt = '0;
              if (row == LAST) begin
                row_nxt   = '0;
                state_nxt = NORM;
              end else begin
                row_nxt = row + CNT_W'(1);
              end
            end else begin
              col_nxt = col + CNT_W'(1);
            end
          end
        end
        NORM: begin
          out_pixel_nxt = (shr_c > (ACC_W + 1)'(255)) ? 8'hFF : shr_c[7:0];
          out_valid_nxt = 1'b1;
          state_nxt     = OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_nxt = 1'b0;
            acc_nxt       = '0;
            state_nxt     = ACCUM;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    pixel_ready_nxt = (state_nxt == ACCUM);
    busy_nxt        = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_gauss_conv_engine.sv
// Bench for gauss_conv_engine: directed and randomized windows compared against an
// arithmetic convolution model; also covers abort, backpressure, async reset and err.
module tb_gauss_conv_engine;

  logic                     clk = 1'b0;
  logic                     n_rst = 1'b0;
  logic [2:0][2:0][7:0]     kern = '0;
  logic [3:0][3:0][7:0]     kern4 = '0;
  logic                     start = 1'b0, abort = 1'b0;
  logic [7:0]               pixel_in = '0;
  logic                     pixel_valid = 1'b0, out_ready = 1'b0;
  logic                     pixel_ready, out_valid, busy, err;
  logic [7:0]               out_pixel;
  logic                     pixel_ready4, out_valid4, busy4, err4;
  logic [7:0]               out_pixel4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gauss_conv_engine #(.SIZE(3), .NORM_SHIFT(8)) dut (
    .clk(clk), .n_rst(n_rst), .kernel(kern), .start(start), .abort(abort),
    .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .err(err)
  );

  gauss_conv_engine #(.SIZE(4), .NORM_SHIFT(8)) dut4 (
    .clk(clk), .n_rst(n_rst), .kernel(kern4), .start(start), .abort(abort),
    .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready4),
    .out_pixel(out_pixel4), .out_valid(out_valid4), .out_ready(out_ready),
    .busy(busy4), .err(err4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Convolution model: weighted sum, round-half-up divide by 256, clamp to 255.
  function automatic int model(input int w[9], input int p[9]);
    int sum = 0;
    int r;
    for (int i = 0; i < 9; i++) sum += w[i] * p[i];
    r = (sum + 128) / 256;
    return (r > 255) ? 255 : r;
  endfunction

  task automatic load_kernel(input int w[9]);
    for (int i = 0; i < 9; i++) kern[i / 3][i % 3] = 8'(w[i]);
  endtask

  task automatic do_start(input string tag);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_pready"}, 32'(pixel_ready), 32'd1);
  endtask

  task automatic do_abort(input string tag);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pready"}, 32'(pixel_ready), 32'd0);
    chk({tag, "_ovalid"}, 32'(out_valid), 32'd0);
  endtask

  // Present one pixel after an optional gap; returns after the accepting edge.
  task automatic send_pixel(input int p, input int gap);
    int n = 0;
    repeat (gap) begin @(negedge clk); pixel_valid = 1'b0; pixel_in = 8'($urandom); end
    @(negedge clk); pixel_in = 8'(p); pixel_valid = 1'b1;
    while (!pixel_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("pixel_timeout", 32'(n), 32'd0);
    @(posedge clk);
  endtask

  // Check latency and result, optionally stall the output, then consume it.
  task automatic recv(input int exp, input string tag, input int stall);
    @(negedge clk); pixel_valid = 1'b0;
    chk({tag, "_lat_norm"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_pixel"}, 32'(out_pixel), 32'(exp));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    if (stall > 0) begin
      pixel_valid = 1'b1;
      repeat (stall) begin
        @(negedge clk); pixel_in = 8'($urandom);
        chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_stall_pixel"}, 32'(out_pixel), 32'(exp));
        chk({tag, "_stall_pready"}, 32'(pixel_ready), 32'd0);
      end
      pixel_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    chk({tag, "_consumed"}, 32'(out_valid), 32'd0);
    chk({tag, "_rearm"}, 32'(pixel_ready), 32'd1);
  endtask

  task automatic run_window(input int w[9], input int p[9], input string tag,
                            input int gap_max, input bit scramble, input int stall);
    for (int i = 0; i < 9; i++) begin
      if (scramble && i == 4)
        for (int k = 0; k < 9; k++) kern[k / 3][k % 3] = 8'($urandom);
      send_pixel(p[i], (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
    end
    recv(model(w, p), tag, stall);
  endtask

  initial begin
    int w[9];
    int p[9];

    // Reset state
    #12;
    chk("rst_pixel", 32'(out_pixel), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pready", 32'(pixel_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("err3", 32'(err), 32'd0);
    chk("err4", 32'(err4), 32'd1);
    @(negedge clk); n_rst = 1'b1;

    // Uniform average, no gaps: 25200 -> 98
    foreach (w[i]) begin w[i] = 28; p[i] = 100; end
    load_kernel(w);
    do_start("uni_start");
    chk("err4_start_busy", 32'(busy4), 32'd0);
    run_window(w, p, "uniform", 0, 1'b0, 0);

    // Point kernel, second window reuses the snapshot
    do_abort("pt_abort");
    foreach (w[i]) begin w[i] = 0; p[i] = 50; end
    w[4] = 128; p[4] = 200;
    load_kernel(w);
    do_start("pt_start");
    run_window(w, p, "point_a", 0, 1'b0, 0);
    chk("point_a_model", 32'(model(w, p)), 32'd100);
    p[4] = 255;
    run_window(w, p, "point_b", 0, 1'b0, 0);

    // Saturation
    do_abort("sat_abort");
    foreach (w[i]) begin w[i] = 255; p[i] = 255; end
    load_kernel(w);
    do_start("sat_start");
    run_window(w, p, "saturate", 0, 1'b0, 5);

    // Random kernels and pixels with gaps, mid-window kernel changes, stalls
    for (int k = 0; k < 3; k++) begin
      do_abort("rnd_abort");
      foreach (w[i]) w[i] = int'($urandom_range(k == 0 ? 40 : 255, 0));
      load_kernel(w);
      do_start("rnd_start");
      for (int win = 0; win < 4; win++) begin
        foreach (p[i]) p[i] = int'($urandom_range(255, 0));
        run_window(w, p, "random", (win % 2 == 1) ? 3 : 0, win >= 2, (win == 1) ? 5 : 0);
      end
    end

    // Abort mid-window with a coincident start, then a clean window
    do_abort("ab_pre");
    foreach (w[i]) begin w[i] = 28; p[i] = 200; end
    load_kernel(w);
    do_start("ab_start");
    for (int i = 0; i < 4; i++) send_pixel(p[i], 0);
    @(negedge clk); abort = 1'b1; start = 1'b1;
    @(negedge clk); abort = 1'b0; start = 1'b0; pixel_valid = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_pready", 32'(pixel_ready), 32'd0);
    @(negedge clk);
    chk("ab_start_ignored", 32'(busy), 32'd0);
    foreach (p[i]) p[i] = 100;
    do_start("ab_restart");
    run_window(w, p, "ab_clean", 0, 1'b0, 0);

    // Async reset while a result is pending in OUT
    foreach (p[i]) p[i] = int'($urandom_range(255, 0));
    for (int i = 0; i < 9; i++) send_pixel(p[i], 0);
    @(negedge clk); pixel_valid = 1'b0;
    @(negedge clk);
    chk("ar_pending", 32'(out_valid), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_pixel", 32'(out_pixel), 32'd0);
    chk("ar_pready", 32'(pixel_ready), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    @(negedge clk); n_rst = 1'b1;

    // Even-SIZE instance never leaves IDLE
    do_start("post_rst_start");
    chk("err4_busy", 32'(busy4), 32'd0);
    chk("err4_pready", 32'(pixel_ready4), 32'd0);
    chk("err4_ovalid", 32'(out_valid4), 32'd0);
    chk("err4_opixel", 32'(out_pixel4), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gauss_conv_engine.md
Name: gauss_conv_engine

Overview:
- Downstream consumer of the Gaussian kernel generator: convolves SIZE×SIZE pixel windows with the generated kernel and produces one blurred 8-bit pixel per window.
- Captures a kernel snapshot on start, then streams window pixels in through a valid/ready handshake.
- Multiply-accumulates one pixel per cycle, normalises by a right shift with rounding and saturation, and presents the result on a valid/ready output handshake to the FAST corner stage.

Parameters:
- SIZE, 4'd3, kernel/window edge length; must be odd.
- NORM_SHIFT, 8, right shift applied to the accumulator; kernel weights are Q0.8.
- ACC_W, 16+$clog2(SIZE*SIZE), accumulator width (derived localparam, not overridable).

Ports:
- clk  in  1  clock.
- n_rst  in  1  reset, asynchronous, active-low.
- kernel  in  [SIZE-1:0][SIZE-1:0][7:0]  weights, kernel[row][col], unsigned.
- start  in  1  in IDLE: snapshot kernel and begin accepting windows.
- abort  in  1  return to IDLE from any state.
- pixel_in  in  8  window pixel, raster order (row outer, col inner).
- pixel_valid  in  1  pixel_in valid.
- pixel_ready  out  1  engine accepts a pixel this cycle.
- out_pixel  out  8  normalised, saturated result.
- out_valid  out  1  out_pixel valid.
- out_ready  in  1  consumer accepts out_pixel.
- busy  out  1  state != IDLE.
- err  out  1  static: 1 when SIZE is even.

Behaviour:
- Clocking: all state on posedge clk; async clear on negedge n_rst.
- Reset values: state=IDLE, acc=0, col=0, row=0, kernel snapshot=0, out_pixel=0, out_valid=0, pixel_ready=0, busy=0.
- err is combinational from SIZE. When err=1, start is ignored and the engine stays in IDLE permanently.
- State machine: IDLE, ACCUM, NORM, OUT.
- IDLE:
  - start=1 & abort=0 & err=0 → latch kernel into snapshot, clear acc/col/row, go to ACCUM.
  - Later changes on the kernel input are ignored until the next start from IDLE.
- ACCUM:
  - pixel_ready=1. A handshake occurs when pixel_valid & pixel_ready.
  - On handshake: acc += pixel_in * snap[row][col] (16-bit product, zero-extended to ACC_W).
  - Counters: col increments; at col=SIZE-1, col wraps to 0 and row increments.
  - On the handshake with row=SIZE-1 & col=SIZE-1: go to NORM; the counters wrap to 0.
  - pixel_valid gaps stall the engine with no state change.
- NORM (exactly 1 cycle, pixel_ready=0):
  - r = (acc + (1<<(NORM_SHIFT-1))) >> NORM_SHIFT; with NORM_SHIFT=0 no rounding term is added.
  - out_pixel = (r > 255) ? 255 : r[7:0].
  - out_valid set to 1; go to OUT.
- OUT:
  - out_valid=1 and out_pixel held stable until out_ready=1.
  - On out_ready: out_valid=0, acc=0, go to ACCUM. The kernel snapshot is retained for the next window.
- Latency: final pixel handshake at cycle t → out_valid high from cycle t+2. Back-to-back windows run at SIZE²+2 cycles each, plus any output stall.
- abort:
  - Highest priority in every state; takes effect the next cycle.
  - state=IDLE, acc=0, counters=0, out_valid=0, pixel_ready=0.
  - A result pending in OUT is discarded. start in the same cycle as abort is ignored.
- start outside IDLE is ignored.
- Accumulator cannot overflow: SIZE²·255·255 < 2^ACC_W.

Test Plan:
- Uniform average: SIZE=3, all weights 28, start, then 9 pixels of 100 with no gaps → out_valid at t+2, out_pixel=98 (acc=25200); busy=1 throughout.
- Point kernel: center weight 128, others 0; window 0..8 with center pixel 200, all other pixels 50 → out_pixel=100. Then a second window with center pixel 255 (no new start) → out_pixel=128, confirming the snapshot is retained.
- Saturation: all weights 255, all pixels 255 → acc=585225, out_pixel=255.
- Backpressure and stalls:
  - Hold out_ready=0 for 5 cycles → out_valid and out_pixel stable, pixel_ready=0, pixel_valid ignored.
  - Insert random pixel_valid gaps → same result as the gap-free run.
  - Change the kernel input mid-window → result unchanged.
- Abort mid-window: after 4 pixels, pulse abort → next cycle IDLE, busy=0, pixel_ready=0. A new start followed by a full uniform window (weights 28, pixels 100) → 98, with no residue from the aborted window.
- Reset/err: assert n_rst low asynchronously while in OUT → all outputs at reset values immediately. Instantiate with SIZE=4 → err=1; start ignored, busy stays 0.
